// File: rtl/eth_echo_ctrl.sv
// Ethernet echo controller: drives an iob_eth core over its register bus,
// receiving each frame and transmitting the same payload back to the peer.
`ifndef ETH_ADDR_W
`define ETH_ADDR_W 12
`endif
`ifndef ETH_STATUS
`define ETH_STATUS 0
`endif
`ifndef ETH_SEND
`define ETH_SEND 1
`endif
`ifndef ETH_RCVACK
`define ETH_RCVACK 2
`endif
`ifndef ETH_SOFTRST
`define ETH_SOFTRST 4
`endif
`ifndef ETH_TX_NBYTES
`define ETH_TX_NBYTES 6
`endif
`ifndef ETH_RX_NBYTES
`define ETH_RX_NBYTES 7
`endif
`ifndef ETH_DATA
`define ETH_DATA 2048
`endif
`ifndef ETH_MAC_ADDR
`define ETH_MAC_ADDR 48'h01_60_6E_11_02_0F
`endif
`ifndef ETH_RMAC_ADDR
`define ETH_RMAC_ADDR 48'h30_9C_23_1E_62_4A
`endif

module eth_echo_ctrl #(
    parameter int          NBYTES        = 238,
    parameter logic [47:0] ETH_MAC_ADDR  = `ETH_MAC_ADDR,
    parameter logic [47:0] ETH_RMAC_ADDR = `ETH_RMAC_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   eth_sel,
    output logic                   eth_we,
    output logic [`ETH_ADDR_W-1:0] eth_addr,
    output logic [31:0]            eth_data_in,
    input  logic [31:0]            eth_data_out,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frame_cnt
);
    localparam int AW = `ETH_ADDR_W;
    localparam int IW = $clog2(NBYTES + 30);
    localparam int BW = $clog2(NBYTES);
    // Preamble, SFD, destination, source, EtherType -- transmitted byte 0 first.
    localparam logic [239:0] HDR = {{15{8'h55}}, 8'hD5, ETH_RMAC_ADDR, ETH_MAC_ADDR, 8'h08, 8'h00};

    typedef enum logic [3:0] {
        IDLE, RST_HI, RST_LO, SET_RXN, WAIT_LINK, POLL_RX, RD_PAY,
        ACK, POLL_TX, SET_TXN, WR_HDR, WR_PAY, SEND
    } state_t;

    // Bus phase: idle gap before issue, first and second cycle of eth_sel.
    typedef enum logic [1:0] {PH_ISSUE, PH_CYC1, PH_CYC2} phase_t;

    state_t        state, nxt_state;
    phase_t        phase;
    logic [IW-1:0] idx;
    logic [7:0]    pay_buf [NBYTES];
    logic          st_link, st_rx_rdy, st_tx_rdy;
    logic          req_we, adv_idx, complete;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic          unused_rd;

    assign unused_rd = ^{eth_data_out[31:16], eth_data_out[14:8]};

    function automatic logic [7:0] hdr_byte(input logic [4:0] i);
        return HDR[8*(29 - int'(i)) +: 8];
    endfunction

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        req_we   = 1'b1;
        req_addr = '0;
        req_data = '0;
        case (state)
            RST_HI:    begin req_addr = AW'(`ETH_SOFTRST);   req_data = 32'd1; end
            RST_LO:    req_addr = AW'(`ETH_SOFTRST);
            SET_RXN:   begin req_addr = AW'(`ETH_RX_NBYTES); req_data = 32'(NBYTES); end
            WAIT_LINK,
            POLL_RX,
            POLL_TX:   begin req_we = 1'b0; req_addr = AW'(`ETH_STATUS); end
            RD_PAY:    begin req_we = 1'b0; req_addr = AW'(`ETH_DATA + 14) + AW'(idx); end
            ACK:       begin req_addr = AW'(`ETH_RCVACK);    req_data = 32'd1; end
            SET_TXN:   begin req_addr = AW'(`ETH_TX_NBYTES); req_data = 32'(NBYTES); end
            WR_HDR:    begin
                req_addr = AW'(`ETH_DATA) + AW'(idx);
                req_data = {24'd0, hdr_byte(idx[4:0])};
            end
            WR_PAY:    begin
                req_addr = AW'(`ETH_DATA + 30) + AW'(idx);
                req_data = {24'd0, pay_buf[idx[BW-1:0]]};
            end
            SEND:      begin req_addr = AW'(`ETH_SEND); req_data = 32'(`ETH_SEND); end
            default:   req_we = 1'b0;
        endcase
    end

    // Where to go once the current transaction completes; reads decide on
    // status bits captured at the first edge of the read.
    always_comb begin
        nxt_state = state;
        adv_idx   = 1'b0;
        case (state)
            IDLE:      if (start) nxt_state = RST_HI;
            RST_HI:    nxt_state = RST_LO;
            RST_LO:    nxt_state = SET_RXN;
            SET_RXN:   nxt_state = WAIT_LINK;
            WAIT_LINK: if (st_link) nxt_state = POLL_RX;
            POLL_RX:   if (!start) nxt_state = IDLE;
                       else if (st_rx_rdy) nxt_state = RD_PAY;
            RD_PAY:    if (idx == IW'(NBYTES - 1)) nxt_state = ACK; else adv_idx = 1'b1;
            ACK:       nxt_state = POLL_TX;
            POLL_TX:   if (st_tx_rdy) nxt_state = SET_TXN;
            SET_TXN:   nxt_state = WR_HDR;
            WR_HDR:    if (idx == IW'(29)) nxt_state = WR_PAY; else adv_idx = 1'b1;
            WR_PAY:    if (idx == IW'(NBYTES - 1)) nxt_state = SEND; else adv_idx = 1'b1;
            SEND:      nxt_state = POLL_RX;
            default:   nxt_state = IDLE;
        endcase
    end

    assign complete = (phase == PH_ISSUE && state == IDLE) ||
                      (phase == PH_CYC1 && eth_we) ||
                      (phase == PH_CYC2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= PH_ISSUE;
            idx         <= '0;
            eth_sel     <= 1'b0;
            eth_we      <= 1'b0;
            eth_addr    <= '0;
            eth_data_in <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            st_link     <= 1'b0;
            st_rx_rdy   <= 1'b0;
            st_tx_rdy   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (phase)
                PH_ISSUE: if (state != IDLE) begin
                    eth_sel     <= 1'b1;
                    eth_we      <= req_we;
                    eth_addr    <= req_addr;
                    eth_data_in <= req_data;
                    phase       <= PH_CYC1;
                end
                PH_CYC1: if (eth_we) begin
                    eth_sel <= 1'b0;
                    eth_we  <= 1'b0;
                    phase   <= PH_ISSUE;
                end else begin
                    st_link   <= eth_data_out[15] & eth_data_out[3];
                    st_rx_rdy <= eth_data_out[1];
                    st_tx_rdy <= eth_data_out[0];
                    phase     <= PH_CYC2;
                end
                PH_CYC2: begin
                    eth_sel <= 1'b0;
                    phase   <= PH_ISSUE;
                end
                default: phase <= PH_ISSUE;
            endcase

            if (complete) begin
                if (nxt_state != state) begin
                    state <= nxt_state;
                    idx   <= '0;
                    busy  <= (nxt_state != IDLE);
                end else if (adv_idx) begin
                    idx <= idx + IW'(1);
                end
                if (state == SEND) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end
            end
        end
    end

    // NOTE: payload storage has no reset; every byte is rewritten before it is sent.
    always_ff @(posedge clk) begin
        if (phase == PH_CYC1 && !eth_we && state == RD_PAY)
            pay_buf[idx[BW-1:0]] <= eth_data_out[7:0];
    end

endmodule

// File: tb/tb_eth_echo_ctrl.sv
// Bench for eth_echo_ctrl: a behavioural iob_eth peer feeds frames, captures
// the transmitted frame and watches the bus protocol.
`ifndef ETH_ADDR_W
`define ETH_ADDR_W 12
`endif
`ifndef ETH_STATUS
`define ETH_STATUS 0
`endif
`ifndef ETH_SEND
`define ETH_SEND 1
`endif
`ifndef ETH_RCVACK
`define ETH_RCVACK 2
`endif
`ifndef ETH_SOFTRST
`define ETH_SOFTRST 4
`endif
`ifndef ETH_TX_NBYTES
`define ETH_TX_NBYTES 6
`endif
`ifndef ETH_RX_NBYTES
`define ETH_RX_NBYTES 7
`endif
`ifndef ETH_DATA
`define ETH_DATA 2048
`endif
`ifndef ETH_MAC_ADDR
`define ETH_MAC_ADDR 48'h01_60_6E_11_02_0F
`endif
`ifndef ETH_RMAC_ADDR
`define ETH_RMAC_ADDR 48'h30_9C_23_1E_62_4A
`endif

module tb_eth_echo_ctrl;
    localparam int NB = 238;
    localparam int AW = `ETH_ADDR_W;
    localparam logic [47:0] MAC  = `ETH_MAC_ADDR;
    localparam logic [47:0] RMAC = `ETH_RMAC_ADDR;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          eth_sel, eth_we, busy, frame_done;
    logic [AW-1:0] eth_addr;
    logic [31:0]   eth_data_in, eth_data_out;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    eth_echo_ctrl #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start),
        .eth_sel(eth_sel), .eth_we(eth_we), .eth_addr(eth_addr),
        .eth_data_in(eth_data_in), .eth_data_out(eth_data_out),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    int n_err = 0;
    int n_chk = 0;

    // Peer state written by the stimulus process.
    logic        link_up = 1'b0;
    logic        pll_locked = 1'b1;
    logic        rx_go = 1'b0;
    logic [31:0] junk = 32'h0;
    logic [7:0]  rx_mem  [NB+14];
    logic [7:0]  exp_pay [NB];
    int          done_base, send_base, hb_base;

    // Peer state written by the bus process.
    logic        rx_ready = 1'b0;
    logic        rx_go_q = 1'b0;
    int          tx_hold = 0;
    logic [7:0]  tx_mem  [NB+30];
    logic [7:0]  last_tx [NB+30];
    logic [AW+31:0] wr_log[$];
    int          send_cnt = 0, softrst_cnt = 0, done_cnt = 0, tx_nbytes_val = 0;
    int          hi_bad_cnt = 0, wr_pay_cnt = 0, rd_pay_cnt = 0;
    int          run = 0;
    logic        run_we = 1'b0;
    logic        prev_fd = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always_comb begin
        eth_data_out = 32'h0;
        if (eth_addr == AW'(`ETH_STATUS))
            eth_data_out = {junk[31:16], link_up, junk[14:4], pll_locked, junk[2], rx_ready, (tx_hold == 0)};
        else if (int'(eth_addr) >= `ETH_DATA && int'(eth_addr) < `ETH_DATA + NB + 14)
            eth_data_out = {junk[31:8], rx_mem[int'(eth_addr) - `ETH_DATA]};
    end

    always @(posedge clk) begin
        check("we_without_sel", 64'(eth_we & ~eth_sel), 64'd0);
        if (rst) begin
            run = 0;
        end else if (eth_sel) begin
            if (run == 0) run_we = eth_we;
            else check("we_stable_in_txn", 64'(eth_we), 64'(run_we));
            run++;
        end else if (run > 0) begin
            check(run_we ? "write_len" : "read_len", 64'(run), run_we ? 64'd1 : 64'd2);
            run = 0;
        end

        if (rx_go != rx_go_q) begin
            rx_ready = 1'b1;
            rx_go_q  = rx_go;
        end

        if (eth_sel && eth_we) begin
            wr_log.push_back({eth_addr, eth_data_in});
            if (eth_addr == AW'(`ETH_SOFTRST) && eth_data_in[0]) begin
                softrst_cnt++;
                rx_ready = 1'b0;
                tx_hold  = 0;
            end else if (eth_addr == AW'(`ETH_RCVACK)) begin
                rx_ready = 1'b0;
                tx_hold  = $urandom_range(0, 12);
            end else if (eth_addr == AW'(`ETH_TX_NBYTES)) begin
                tx_nbytes_val = int'(eth_data_in);
            end else if (eth_addr == AW'(`ETH_SEND)) begin
                check("send_data", 64'(eth_data_in), 64'(`ETH_SEND));
                send_cnt++;
                last_tx = tx_mem;
            end else if (int'(eth_addr) >= `ETH_DATA && int'(eth_addr) < `ETH_DATA + NB + 30) begin
                tx_mem[int'(eth_addr) - `ETH_DATA] = eth_data_in[7:0];
                if (|eth_data_in[31:8]) hi_bad_cnt++;
                if (int'(eth_addr) >= `ETH_DATA + 70) wr_pay_cnt++;
            end
        end else if (eth_sel && int'(eth_addr) >= `ETH_DATA + 34 && int'(eth_addr) < `ETH_DATA + NB + 14) begin
            rd_pay_cnt++;
        end

        if (!eth_sel && tx_hold > 0) tx_hold--;
        if (frame_done) begin
            done_cnt++;
            check("frame_done_one_cycle", 64'(prev_fd), 64'd0);
        end
        prev_fd = frame_done;
    end

    function automatic logic [7:0] exp_byte(input int i);
        if (i < 15)  return 8'h55;
        if (i == 15) return 8'hD5;
        if (i < 22)  return 8'(RMAC >> (8 * (21 - i)));
        if (i < 28)  return 8'(MAC >> (8 * (27 - i)));
        if (i == 28) return 8'h08;
        if (i == 29) return 8'h00;
        return exp_pay[i - 30];
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start the controller and let it reach the receive poll loop.
    task automatic init_and_park(input string tag);
        int base = wr_log.size();
        link_up = 1'b0;
        start   = 1'b1;
        cycles($urandom_range(20, 60));
        check({tag, "_busy_wait_link"}, 64'(busy), 64'd1);
        link_up = 1'b1;
        cycles(60);
        check({tag, "_init_writes"}, 64'(wr_log.size() - base), 64'd3);
        check({tag, "_softrst_hi"}, 64'(wr_log[base]),     {20'd0, AW'(`ETH_SOFTRST),   32'd1});
        check({tag, "_softrst_lo"}, 64'(wr_log[base + 1]), {20'd0, AW'(`ETH_SOFTRST),   32'd0});
        check({tag, "_rx_nbytes"},  64'(wr_log[base + 2]), {20'd0, AW'(`ETH_RX_NBYTES), 32'(NB)});
        check({tag, "_busy_parked"}, 64'(busy), 64'd1);
    endtask

    // mode 0: greeting text, 1: (k+n) mod 256, 2: random bytes.
    task automatic load_frame(input int mode, input int n);
        string hello = "Hello from PC!";
        junk = $urandom;
        for (int k = 0; k < NB; k++) begin
            case (mode)
                0:       exp_pay[k] = (k < hello.len()) ? hello[k] : 8'h00;
                1:       exp_pay[k] = 8'((k + n) % 256);
                default: exp_pay[k] = 8'($urandom);
            endcase
            rx_mem[14 + k] = exp_pay[k];
        end
        for (int k = 0; k < 14; k++) rx_mem[k] = 8'($urandom);
        done_base = done_cnt;
        send_base = send_cnt;
        hb_base   = hi_bad_cnt;
        rx_go     = ~rx_go;
    endtask

    task automatic expect_echo(input string tag);
        int t = 0;
        int bad = 0;
        while (done_cnt == done_base && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_within_budget"}, 64'(t < 6000), 64'd1);
        cycles(4);
        check({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
        check({tag, "_sends"}, 64'(send_cnt - send_base), 64'd1);
        for (int i = 0; i < NB + 30; i++)
            if (last_tx[i] !== exp_byte(i)) bad++;
        check({tag, "_tx_bytes_wrong"}, 64'(bad), 64'd0);
        check({tag, "_tx_upper_bits_set"}, 64'(hi_bad_cnt - hb_base), 64'd0);
        check({tag, "_tx_nbytes"}, 64'(tx_nbytes_val), 64'(NB));
    endtask

    initial begin
        int t;
        int sr0;
        int mark;

        rst = 1'b1;
        start = 1'b0;
        cycles(3);
        check("rst_sel", 64'(eth_sel), 64'd0);
        check("rst_we", 64'(eth_we), 64'd0);
        check("rst_addr", 64'(eth_addr), 64'd0);
        check("rst_data_in", 64'(eth_data_in), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;
        cycles(5);
        check("idle_without_start", 64'({busy, eth_sel}), 64'd0);

        init_and_park("init1");
        load_frame(0, 0);
        expect_echo("hello");
        check("hello_frame_cnt", 64'(frame_cnt), 64'd1);

        start = 1'b0;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        init_and_park("init2");
        sr0 = softrst_cnt;
        for (int n = 0; n < 3; n++) begin
            load_frame(1, n);
            expect_echo($sformatf("ramp%0d", n));
        end
        check("ramp_frame_cnt", 64'(frame_cnt), 64'd3);
        check("ramp_no_softrst", 64'(softrst_cnt - sr0), 64'd0);

        load_frame(2, 0);
        expect_echo("random");
        check("random_frame_cnt", 64'(frame_cnt), 64'd4);

        // Drop start while polling for receive.
        cycles($urandom_range(0, 5));
        start = 1'b0;
        cycles(3);
        check("stop_poll_busy", 64'(busy), 64'd0);
        check("stop_poll_sel", 64'(eth_sel), 64'd0);

        // Drop start while the payload is being written back.
        init_and_park("init3");
        mark = wr_pay_cnt;
        load_frame(2, 0);
        t = 0;
        while (wr_pay_cnt == mark && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("wr_pay_reached", 64'(t < 3000), 64'd1);
        start = 1'b0;
        expect_echo("stop_in_wr_pay");
        t = 0;
        while (busy && t < 8) begin
            @(negedge clk);
            t++;
        end
        check("stop_wr_pay_idle", 64'(busy), 64'd0);
        check("stop_wr_pay_frame_cnt", 64'(frame_cnt), 64'd5);

        // Reset in the middle of payload reads, then restart.
        init_and_park("init4");
        mark = rd_pay_cnt;
        load_frame(2, 0);
        t = 0;
        while (rd_pay_cnt == mark && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("rd_pay_reached", 64'(t < 3000), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sel", 64'(eth_sel), 64'd0);
        check("midrst_we", 64'(eth_we), 64'd0);
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        init_and_park("init5");
        load_frame(2, 0);
        expect_echo("after_midrst");
        check("after_midrst_frame_cnt", 64'(frame_cnt), 64'd1);

        start = 1'b0;
        cycles(10);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
